im_fetch_ctrl: RTL

//  Fetch sequencer for the synchronous instruction memory (byte-addressed, big-endian 4-byte words, 1-cycle read).

---
 rtl/im_fetch_ctrl_pkg.sv | 26 ++
 rtl/im_fetch_ctrl_if.sv | 30 +++
 rtl/im_fetch_fifo.sv | 55 +++++
 rtl/im_fetch_ctrl.sv | 114 +++++++++++
 4 files changed

// File: rtl/im_fetch_ctrl_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
//   fetch_state_e : sequencer state (idle, running, stopped out of range)
//   fetch_entry_t : one buffered fetch result {pc, instr}
//   word_align()  : clears the byte-offset bits of an address
package im_fetch_ctrl_pkg;

  localparam int unsigned ADDR_W      = 32;
  localparam int unsigned INSTR_W     = 32;
  localparam int unsigned INSTR_BYTES = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_OOB  = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

  function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] addr);
    return {addr[ADDR_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/im_fetch_ctrl_if.sv
// Fetch sequencer bus: control inputs, IM address/data, decode handshake, error flags.
//   master : the fetch sequencer
//   slave  : the environment (IM, decode, branch unit)
interface im_fetch_ctrl_if
  import im_fetch_ctrl_pkg::*;
();

  logic               fetch_en;
  logic               redirect_valid;
  logic [ADDR_W-1:0]  redirect_pc;
  logic [ADDR_W-1:0]  im_addr;
  logic [INSTR_W-1:0] im_data;
  logic               instr_valid;
  logic [INSTR_W-1:0] instr;
  logic [ADDR_W-1:0]  instr_pc;
  logic               instr_ready;
  logic               oob_err;
  logic               misalign_err;

  modport master (
    input  fetch_en, redirect_valid, redirect_pc, im_data, instr_ready,
    output im_addr, instr_valid, instr, instr_pc, oob_err, misalign_err
  );

  modport slave (
    output fetch_en, redirect_valid, redirect_pc, im_data, instr_ready,
    input  im_addr, instr_valid, instr, instr_pc, oob_err, misalign_err
  );

endinterface

// File: rtl/im_fetch_fifo.sv
// Small shift-style FIFO of {pc, instr} entries; head is always slot 0.
//   clk, rst_n : clock, async active-low reset
//   flush      : synchronous empty (data kept so the head output holds)
//   wr_en/wr_data, rd_en : push / pop (simultaneous allowed)
//   head, count          : slot 0 and occupancy
module im_fetch_fifo
  import im_fetch_ctrl_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       wr_en,
  input  fetch_entry_t               wr_data,
  input  logic                       rd_en,
  output fetch_entry_t               head,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  fetch_entry_t  mem [DEPTH];
  logic [CW-1:0] wr_slot_c;

  // A push lands behind the surviving entries after any pop this cycle.
  assign wr_slot_c = count - CW'(rd_en);
  assign head      = mem[0];

  // Storage and occupancy; slots past the occupancy are left untouched so
  // slot 0 keeps the last head after the FIFO empties.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      count <= '0;
    end else begin
      for (int unsigned i = 0; i + 1 < DEPTH; i++) begin
        if (rd_en && (CW'(i + 1) < count)) mem[i] <= mem[i + 1];
      end
      if (wr_en) mem[IW'(wr_slot_c)] <= wr_data;
      count <= count + CW'(wr_en) - CW'(rd_en);
    end
  end

  // The issue credit in the sequencer must never let a push hit a full FIFO.
  always_ff @(posedge clk) begin
    if (rst_n && !flush) begin
      assert (!(wr_en && !rd_en && (count == CW'(DEPTH))));
    end
  end

endmodule

// File: rtl/im_fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, issues 1-cycle IM reads, buffers
// returned words and hands them to decode over valid/ready.
//   clk, rst_n : clock, async active-low reset
//   bus        : im_fetch_ctrl_if.master (controls, IM port, decode port, errors)
module im_fetch_ctrl
  import im_fetch_ctrl_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC   = 32'h0,
  parameter int unsigned       MEM_BYTES  = 1024,
  parameter int unsigned       FIFO_DEPTH = 2
) (
  input logic          clk,
  input logic          rst_n,
  im_fetch_ctrl_if.master bus
);

  localparam int unsigned       CW      = $clog2(FIFO_DEPTH + 1);
  localparam logic [ADDR_W-1:0] LAST_PC = ADDR_W'(MEM_BYTES - INSTR_BYTES);

  fetch_state_e      state, state_n;
  logic [ADDR_W-1:0] pc, pc_n;
  logic              inflight, inflight_n;
  logic [ADDR_W-1:0] inflight_pc, inflight_pc_n;
  logic              oob_q, oob_n;
  logic              mis_q, mis_n;

  logic [CW-1:0]     fifo_count;
  fetch_entry_t      fifo_head;
  fetch_entry_t      fifo_wdata_c;
  logic              valid_c;
  logic              deq_c;
  logic              fifo_wr_c;
  logic              credit_ok_c;

  assign valid_c      = (fifo_count != '0);
  assign deq_c        = valid_c && bus.instr_ready;
  // A returning word is dropped when a redirect squashes it.
  assign fifo_wr_c    = inflight && !bus.redirect_valid;
  assign fifo_wdata_c = '{pc: inflight_pc, instr: bus.im_data};
  // Count the in-flight read as occupied so its return always has a slot.
  assign credit_ok_c  = ((CW+1)'(fifo_count) + (CW+1)'(inflight) - (CW+1)'(deq_c))
                        < (CW+1)'(FIFO_DEPTH);

  // State, PC and flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      pc          <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= '0;
      oob_q       <= 1'b0;
      mis_q       <= 1'b0;
    end else begin
      state       <= state_n;
      pc          <= pc_n;
      inflight    <= inflight_n;
      inflight_pc <= inflight_pc_n;
      oob_q       <= oob_n;
      mis_q       <= mis_n;
    end
  end

  // Next-state: redirect overrides everything, then state-specific issue rules.
  always_comb begin
    state_n       = state;
    pc_n          = pc;
    inflight_n    = 1'b0;
    inflight_pc_n = inflight_pc;
    mis_n         = 1'b0;
    if (bus.redirect_valid) begin
      pc_n  = word_align(bus.redirect_pc);
      mis_n = |bus.redirect_pc[1:0];
      if (state != S_IDLE) state_n = (pc_n <= LAST_PC) ? S_RUN : S_OOB;
    end else begin
      case (state)
        S_IDLE: if (bus.fetch_en) state_n = S_RUN;
        S_RUN: begin
          if (bus.fetch_en) begin
            if (pc > LAST_PC) begin
              state_n = S_OOB;
            end else if (credit_ok_c) begin
              inflight_n    = 1'b1;
              inflight_pc_n = pc;
              pc_n          = pc + ADDR_W'(INSTR_BYTES);
            end
          end
        end
        default: ;
      endcase
    end
    oob_n = (state_n == S_OOB);
  end

  im_fetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush   (bus.redirect_valid),
    .wr_en   (fifo_wr_c),
    .wr_data (fifo_wdata_c),
    .rd_en   (deq_c),
    .head    (fifo_head),
    .count   (fifo_count)
  );

  assign bus.im_addr      = pc;
  assign bus.instr_valid  = valid_c;
  assign bus.instr        = fifo_head.instr;
  assign bus.instr_pc     = fifo_head.pc;
  assign bus.oob_err      = oob_q;
  assign bus.misalign_err = mis_q;

endmodule
